branch_resolve: RTL and testbench

- Consumer of the 2-bit compare code produced by the decode-stage comparator.
- Combines the code with the branch opcode to decide taken or not-taken.
- For a taken branch, registers the target and holds a redirect request to the fetch stage until fetch accepts it, stalling decode meanwhile, then pulses a one-cycle IF/ID flush.
- Keeps saturating branch and taken-branch counters for performance debug.

---
 rtl/branch_resolve_if.sv | 25 ++
 rtl/branch_resolve.sv | 95 +++++++++
 tb/tb_branch_resolve.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_if.sv
// Decode/fetch-side signals of the branch resolver: branch request in,
// redirect request and decode stall/flush controls out.
interface branch_resolve_if #(
  parameter int ADDR_W = 32
) ();
  logic              br_valid;
  logic [2:0]        br_op;
  logic [1:0]        cmp_result;
  logic [ADDR_W-1:0] br_target;
  logic              fetch_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              stall_id;
  logic              flush_id;

  modport master (
    output br_valid, br_op, cmp_result, br_target, fetch_ready,
    input  redirect_valid, redirect_pc, stall_id, flush_id
  );

  modport slave (
    input  br_valid, br_op, cmp_result, br_target, fetch_ready,
    output redirect_valid, redirect_pc, stall_id, flush_id
  );
endinterface

// File: rtl/branch_resolve.sv
// Branch resolution: turns the decode compare code plus branch opcode into a
// held fetch redirect, a one-cycle IF/ID flush and saturating statistics.
module branch_resolve #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  branch_resolve_if.slave  bus,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic {IDLE, REDIR} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              redir_q;
  logic              flush_q;
  logic [CNT_W-1:0]  branch_cnt_q;
  logic [CNT_W-1:0]  taken_cnt_q;
  logic              taken;
  logic              accept;

  always_comb begin
    taken = 1'b0;
    unique case (bus.br_op)
      3'b001:  taken = (bus.cmp_result == 2'b01);
      3'b010:  taken = (bus.cmp_result == 2'b10) || (bus.cmp_result == 2'b11);
      3'b011:  taken = (bus.cmp_result == 2'b10);
      3'b100:  taken = (bus.cmp_result == 2'b11);
      3'b101:  taken = (bus.cmp_result == 2'b10) || (bus.cmp_result == 2'b01);
      3'b110:  taken = (bus.cmp_result == 2'b11) || (bus.cmp_result == 2'b01);
      3'b111:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // Branches presented while a redirect is pending are dropped entirely.
  assign accept = (state_q == IDLE) && bus.br_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      redir_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.br_valid && taken) begin
            pc_q    <= bus.br_target;
            redir_q <= 1'b1;
            state_q <= REDIR;
          end
        end
        REDIR: begin
          if (bus.fetch_ready) begin
            redir_q <= 1'b0;
            flush_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else if (clr_cnt) begin
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else if (accept) begin
      if ((bus.br_op != 3'b000) && (branch_cnt_q != CNT_MAX))
        branch_cnt_q <= branch_cnt_q + 1'b1;
      if (taken && (taken_cnt_q != CNT_MAX))
        taken_cnt_q <= taken_cnt_q + 1'b1;
    end
  end

  assign bus.redirect_valid = redir_q;
  assign bus.redirect_pc    = pc_q;
  assign bus.stall_id       = redir_q;
  assign bus.flush_id       = flush_q;
  assign branch_cnt         = branch_cnt_q;
  assign taken_cnt          = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: a 16-bit-counter and a 4-bit-counter
// instance share one stimulus stream and are compared against a cycle model.
module tb_branch_resolve;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              br_valid = 1'b0;
  logic [2:0]        br_op = '0;
  logic [1:0]        cmp_result = '0;
  logic [ADDR_W-1:0] br_target = '0;
  logic              fetch_ready = 1'b0;
  logic              clr_cnt = 1'b0;
  logic [15:0]       bc16, tc16;
  logic [3:0]        bc4, tc4;

  int checks = 0;
  int errors = 0;

  branch_resolve_if #(.ADDR_W(ADDR_W)) bus_a ();
  branch_resolve_if #(.ADDR_W(ADDR_W)) bus_b ();

  assign bus_a.br_valid    = br_valid;
  assign bus_a.br_op       = br_op;
  assign bus_a.cmp_result  = cmp_result;
  assign bus_a.br_target   = br_target;
  assign bus_a.fetch_ready = fetch_ready;
  assign bus_b.br_valid    = br_valid;
  assign bus_b.br_op       = br_op;
  assign bus_b.cmp_result  = cmp_result;
  assign bus_b.br_target   = br_target;
  assign bus_b.fetch_ready = fetch_ready;

  branch_resolve #(.ADDR_W(ADDR_W), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .clr_cnt(clr_cnt),
    .branch_cnt(bc16), .taken_cnt(tc16)
  );

  branch_resolve #(.ADDR_W(ADDR_W), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .clr_cnt(clr_cnt),
    .branch_cnt(bc4), .taken_cnt(tc4)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit                m_redir;
  logic [ADDR_W-1:0] m_pc;
  bit                m_flush;
  int                m_bc16, m_tc16, m_bc4, m_tc4;

  // Branch semantics expressed as relations on the compared value vs zero.
  function automatic bit ref_taken(input logic [2:0] op, input logic [1:0] cmp);
    bit eq, lt, gt;
    if (op == 3'd7) return 1'b1;
    if (op == 3'd0 || cmp == 2'd0) return 1'b0;
    eq = (cmp == 2'd1);
    lt = (cmp == 2'd2);
    gt = (cmp == 2'd3);
    case (op)
      3'd1: return eq;
      3'd2: return !eq;
      3'd3: return lt;
      3'd4: return gt;
      3'd5: return !gt;
      3'd6: return !lt;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int sat_inc(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  task automatic model_reset();
    m_redir = 0; m_pc = '0; m_flush = 0;
    m_bc16 = 0; m_tc16 = 0; m_bc4 = 0; m_tc4 = 0;
  endtask

  task automatic model_edge();
    bit acc, tk, fl;
    if (rst) begin
      model_reset();
      return;
    end
    acc = !m_redir && br_valid;
    tk  = ref_taken(br_op, cmp_result);
    fl  = m_redir && fetch_ready;
    if (m_redir) begin
      if (fetch_ready) m_redir = 0;
    end else if (acc && tk) begin
      m_redir = 1;
      m_pc    = br_target;
    end
    if (clr_cnt) begin
      m_bc16 = 0; m_tc16 = 0; m_bc4 = 0; m_tc4 = 0;
    end else if (acc) begin
      if (br_op != 3'd0) begin
        m_bc16 = sat_inc(m_bc16, 65535);
        m_bc4  = sat_inc(m_bc4, 15);
      end
      if (tk) begin
        m_tc16 = sat_inc(m_tc16, 65535);
        m_tc4  = sat_inc(m_tc4, 15);
      end
    end
    m_flush = fl;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, " redirect_valid"}, 64'(bus_a.redirect_valid), 64'(m_redir));
    check({tag, " redirect_pc"},    64'(bus_a.redirect_pc),    64'(m_pc));
    check({tag, " stall_id"},       64'(bus_a.stall_id),       64'(m_redir));
    check({tag, " flush_id"},       64'(bus_a.flush_id),       64'(m_flush));
    check({tag, " branch_cnt16"},   64'(bc16),                 64'(m_bc16));
    check({tag, " taken_cnt16"},    64'(tc16),                 64'(m_tc16));
    check({tag, " branch_cnt4"},    64'(bc4),                  64'(m_bc4));
    check({tag, " taken_cnt4"},     64'(tc4),                  64'(m_tc4));
    check({tag, " redirect_valid4"}, 64'(bus_b.redirect_valid), 64'(m_redir));
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    br_valid = 0; fetch_ready = 0; clr_cnt = 0;
  endtask

  task automatic branch(input logic [2:0] op, input logic [1:0] cmp, input logic [ADDR_W-1:0] tgt);
    br_valid = 1; br_op = op; cmp_result = cmp; br_target = tgt;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [1:0] cmp;
    bit         exp_taken;
  } vec_t;

  vec_t       vecs[32];
  logic [3:0] tt[8];

  initial begin
    model_reset();
    @(negedge clk);
    step("reset0");
    step("reset1");
    check("reset rv", 64'(bus_a.redirect_valid), 64'd0);
    check("reset bc", 64'(bc16), 64'd0);
    rst = 0;
    idle_inputs();
    step("release");

    // BEQ taken with immediate accept
    branch(3'd1, 2'd1, 32'h0000_1000); fetch_ready = 1;
    step("beq accept");
    check("beq rv", 64'(bus_a.redirect_valid), 64'd1);
    check("beq pc", 64'(bus_a.redirect_pc), 64'h1000);
    br_valid = 0;
    step("beq release");
    check("beq flush", 64'(bus_a.flush_id), 64'd1);
    check("beq rv drop", 64'(bus_a.redirect_valid), 64'd0);
    check("beq bc", 64'(bc16), 64'd1);
    check("beq tc", 64'(tc16), 64'd1);
    idle_inputs();
    step("beq after");
    check("beq flush once", 64'(bus_a.flush_id), 64'd0);

    // Held redirect with a spurious branch during the hold
    branch(3'd6, 2'd3, 32'h0000_2000);
    step("bgez accept");
    for (int i = 0; i < 5; i++) begin
      if (i == 2) branch(3'd7, 2'd0, 32'h0000_3000); else br_valid = 0;
      fetch_ready = 0;
      step("bgez hold");
      check("hold stall", 64'(bus_a.stall_id), 64'd1);
      check("hold pc", 64'(bus_a.redirect_pc), 64'h2000);
    end
    br_valid = 0; fetch_ready = 1;
    step("bgez release");
    check("hold flush", 64'(bus_a.flush_id), 64'd1);
    check("hold bc", 64'(bc16), 64'd2);
    idle_inputs();
    step("bgez after");

    // Truth-table sweep; nibble bit index is the compare code
    tt[0] = 4'b0000; tt[1] = 4'b0010; tt[2] = 4'b1100; tt[3] = 4'b0100;
    tt[4] = 4'b1000; tt[5] = 4'b0110; tt[6] = 4'b1010; tt[7] = 4'b1111;
    for (int o = 0; o < 8; o++)
      for (int c = 0; c < 4; c++) begin
        vecs[o*4+c].op        = 3'(o);
        vecs[o*4+c].cmp       = 2'(c);
        vecs[o*4+c].exp_taken = tt[o][c];
      end
    for (int i = 0; i < 32; i++) begin
      branch(vecs[i].op, vecs[i].cmp, 32'h0000_4000 + 32'(i * 4)); fetch_ready = 0;
      step("sweep");
      check($sformatf("sweep op%0d cmp%0d taken", vecs[i].op, vecs[i].cmp),
            64'(bus_a.redirect_valid), 64'(vecs[i].exp_taken));
      br_valid = 0; fetch_ready = 1;
      step("sweep drain");
      idle_inputs();
      step("sweep idle");
    end

    // Saturation on the 4-bit instance, then clear with simultaneous accept
    clr_cnt = 1;
    step("sat clear");
    clr_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      branch(3'd7, 2'($urandom_range(0, 3)), 32'(i)); fetch_ready = 0;
      step("sat jump");
      br_valid = 0; fetch_ready = 1;
      step("sat drain");
    end
    check("sat bc4", 64'(bc4), 64'd15);
    check("sat tc4", 64'(tc4), 64'd15);
    check("sat bc16", 64'(bc16), 64'd20);
    branch(3'd7, 2'd0, 32'h0000_5000); fetch_ready = 0; clr_cnt = 1;
    step("clr+accept");
    check("clr bc4", 64'(bc4), 64'd0);
    check("clr tc16", 64'(tc16), 64'd0);
    clr_cnt = 0; br_valid = 0; fetch_ready = 1;
    step("clr drain");

    // Back-to-back: new taken branch in the flush cycle
    branch(3'd2, 2'd2, 32'h0000_6000); fetch_ready = 0;
    step("b2b first");
    br_valid = 0; fetch_ready = 1;
    step("b2b release");
    check("b2b flush", 64'(bus_a.flush_id), 64'd1);
    branch(3'd4, 2'd3, 32'h0000_7000); fetch_ready = 0;
    step("b2b second");
    check("b2b rv", 64'(bus_a.redirect_valid), 64'd1);
    check("b2b pc", 64'(bus_a.redirect_pc), 64'h7000);
    check("b2b flush end", 64'(bus_a.flush_id), 64'd0);

    // Asynchronous reset mid-redirect
    branch(3'd7, 2'd0, 32'h0040_0100);
    idle_inputs(); fetch_ready = 1;
    step("pre-rst drain");
    branch(3'd7, 2'd0, 32'h0040_0100); fetch_ready = 0;
    step("pre-rst redir");
    check("pre-rst pc", 64'(bus_a.redirect_pc), 64'h0040_0100);
    idle_inputs();
    rst = 1;
    #1;
    check("async rv", 64'(bus_a.redirect_valid), 64'd0);
    check("async stall", 64'(bus_a.stall_id), 64'd0);
    check("async flush", 64'(bus_a.flush_id), 64'd0);
    check("async bc", 64'(bc16), 64'd0);
    check("async tc", 64'(tc16), 64'd0);
    model_reset();
    @(negedge clk);
    step("rst hold");
    rst = 0; fetch_ready = 1;
    step("rst release");
    check("post-rst idle", 64'(bus_a.redirect_valid), 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      br_valid    = 1'($urandom_range(0, 1));
      br_op       = 3'($urandom_range(0, 7));
      cmp_result  = 2'($urandom_range(0, 3));
      br_target   = $urandom;
      fetch_ready = ($urandom_range(0, 2) == 0);
      clr_cnt     = ($urandom_range(0, 29) == 0);
      rst         = ($urandom_range(0, 79) == 0);
      step("random");
    end
    rst = 0;
    idle_inputs();
    step("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
